fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Parametrised multi-cycle fetch/sequence controller: successor to the fixed fsm + program_counter + pc_incr trio.
//  Fetches an instruction from a BRAM port with configurable read latency and holds it in an instruction register.
//  Hands the instruction to decoder/datapath and waits for completion; supports stall, relative branch, absolute jump and halt/resume.
//  Sits between dpram port A and the decoder inside CPU; pc and retired feed debug/7-seg.
// PARAMETERS
//  ADDR_W    16  PC / memory address width (>=4)
//  INSTR_W   16  instruction width
//  DISP_W     8  signed branch displacement width (<=ADDR_W)
//  MEM_LAT    1  BRAM read latency in cycles (1..4)
//  RESET_PC   0  PC value loaded on reset
// PORTS
//  clk          in   1        clock, all state on rising edge
//  reset        in   1        synchronous, active-high
//  mem_en       out  1        BRAM read enable, high only in FETCH
//  mem_addr     out  ADDR_W   BRAM read address (= pc)
//  mem_rdata    in   INSTR_W  BRAM read data
//  instr        out  INSTR_W  instruction register
//  instr_valid  out  1        one-cycle pulse in DECODE
//  exec_done    in   1        datapath finished current instruction
//  stall        in   1        hold EXEC even if exec_done
//  br_take      in   1        take relative branch at completion
//  br_disp      in   DISP_W   signed displacement
//  jmp_take     in   1        take absolute jump at completion
//  jmp_addr     in   ADDR_W   jump target
//  halt_req     in   1        enter HALT after current instruction
//  resume       in   1        leave HALT
//  halted       out  1        high in HALT
//  pc           out  ADDR_W   current PC
//  retired      out  16       retired-instruction count, wraps at 2^16
//  state        out  3        FETCH=0 WAIT=1 DECODE=2 EXEC=3 HALT=4
// BEHAVIOUR
//  Reset (sync, any state): state=FETCH, pc=RESET_PC, instr=0, retired=0, lat counter=0.
//   While reset high: mem_en=0, instr_valid=0, halted=0; in-flight read discarded.
//  FETCH: mem_en=1, mem_addr=pc; load lat counter=MEM_LAT; -> WAIT.
//  WAIT: counter decrements each cycle. When counter==1: instr<=mem_rdata at that edge, -> DECODE.
//   WAIT lasts exactly MEM_LAT cycles.
//  DECODE: instr_valid=1 for exactly this cycle; -> EXEC.
//  EXEC: completes on the edge where exec_done=1 && stall=0; otherwise stays.
//   exec_done already high on EXEC entry completes in 1 cycle.
//  Completion edge, all sampled in the same cycle:
//   - pc update priority: jmp_take -> jmp_addr; else br_take -> pc+sext(br_disp); else pc+1.
//   - retired += 1.
//   - next state: HALT if halt_req, else FETCH.
//  Arithmetic: pc math modulo 2^ADDR_W (wraps); br_disp sign-extended; disp 0 = self-loop.
//  HALT: halted=1, mem_en=0, pc/instr/retired held; resume=1 -> FETCH next edge.
//   resume outside HALT ignored; halt_req, br_take, jmp_take, stall ignored outside EXEC.
//  Min instruction period = MEM_LAT+3 cycles (FETCH, WAIT x MEM_LAT, DECODE, EXEC x1).
//  instr stable from DECODE until next WAIT capture.
//  Unused state encodings recover to FETCH next edge.
// TESTING
//  MEM_LAT=1, mem[0]=16'hA001, exec_done tied 1
//   -> mem_en at cycle 1, instr_valid at cycle 3 with instr=A001, pc=1 and retired=1 after cycle 4.
//  MEM_LAT=3 -> 6-cycle period; instr_valid pulses every 6 cycles; mem_en high 1 cycle per instruction.
//  pc=16'h0010, br_take=1, br_disp=8'hFE -> pc=000E.
//   Same cycle also jmp_take=1, jmp_addr=1234 -> pc=1234 (jump wins).
//  pc=FFFF with no branch -> pc wraps to 0000; br_disp=8'h02 at pc=FFFF -> 0001.
//  stall=1 for 5 cycles with exec_done=1 -> EXEC held 5 extra cycles, pc unchanged until stall drops.
//  halt_req at completion -> halted=1 next cycle, pc already advanced, no mem_en.
//   Resume pulse -> FETCH. Reset asserted in WAIT -> pc=RESET_PC, instr=0, next instr_valid from fresh fetch.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/sequence controller: fetches from a fixed-latency BRAM port,
// holds the instruction, hands it to the datapath and steps the PC on completion.
module fetch_sequencer #(
   parameter int unsigned            ADDR_W   = 16,
   parameter int unsigned            INSTR_W  = 16,
   parameter int unsigned            DISP_W   = 8,
   parameter int unsigned            MEM_LAT  = 1,
   parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                mem_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [INSTR_W-1:0]  mem_rdata,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   input  logic                exec_done,
   input  logic                stall,
   input  logic                br_take,
   input  logic [DISP_W-1:0]   br_disp,
   input  logic                jmp_take,
   input  logic [ADDR_W-1:0]   jmp_addr,
   input  logic                halt_req,
   input  logic                resume,
   output logic                halted,
   output logic [ADDR_W-1:0]   pc,
   output logic [15:0]         retired,
   output logic [2:0]          state
);

   localparam int unsigned LAT_W = 3;
   localparam int unsigned RET_W = 16;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [RET_W-1:0]    retired_q, retired_d;
   logic [LAT_W-1:0]    lat_q, lat_d;

   logic                done_c;
   logic [ADDR_W-1:0]   disp_ext_c;
   logic [ADDR_W-1:0]   pc_next_c;

   // Completion target: jump beats branch beats sequential step, all modulo 2^ADDR_W.
   always_comb begin
      done_c     = exec_done && !stall;
      disp_ext_c = ADDR_W'($signed(br_disp));
      if (jmp_take) begin
         pc_next_c = jmp_addr;
      end else if (br_take) begin
         pc_next_c = pc_q + disp_ext_c;
      end else begin
         pc_next_c = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
         lat_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         lat_q     <= lat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      lat_d     = lat_q;
      case (state_q)
         ST_FETCH: begin
            lat_d   = LAT_W'(MEM_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Read data is valid on the last WAIT cycle; capture it at that edge.
            if (lat_q <= LAT_W'(1)) begin
               instr_d = mem_rdata;
               lat_d   = '0;
               state_d = ST_DECODE;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (done_c) begin
               pc_d      = pc_next_c;
               retired_d = retired_q + RET_W'(1);
               state_d   = halt_req ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Strobes are state decodes, forced low while reset is held.
   always_comb begin
      mem_en      = (state_q == ST_FETCH)  && !reset;
      instr_valid = (state_q == ST_DECODE) && !reset;
      halted      = (state_q == ST_HALT)   && !reset;
      mem_addr    = pc_q;
      instr       = instr_q;
      pc          = pc_q;
      retired     = retired_q;
      state       = state_q;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: MEM_LAT=1 instance under full stimulus,
// MEM_LAT=3 instance free-running alongside for period and fetch-count checks.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;

   logic        mem_en1, instr_valid1, halted1;
   logic [15:0] mem_addr1, mem_rdata1, instr1, pc1, retired1;
   logic [2:0]  state1;
   logic        exec_done, stall, br_take, jmp_take, halt_req, resume;
   logic [7:0]  br_disp;
   logic [15:0] jmp_addr;

   logic        mem_en3, instr_valid3, halted3;
   logic [15:0] mem_addr3, mem_rdata3, instr3, pc3, retired3;
   logic [2:0]  state3;

   logic [15:0] pipe1;
   logic [15:0] pipe3 [0:2];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int d3_prev  = -1;
   int d3_memcnt = 0;
   logic [15:0] d3_pc = 16'h0100;
   logic [15:0] model_pc;
   logic [15:0] model_ret;
   logic [15:0] sb [$];

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return (a == 16'h0000) ? 16'hA001 : (a ^ 16'hC3C3);
   endfunction

   // Behavioural BRAMs: latency 1 and latency 3 read pipelines.
   always @(posedge clk) begin
      pipe1    <= mem_en1 ? memf(mem_addr1) : 16'h0000;
      pipe3[0] <= mem_en3 ? memf(mem_addr3) : 16'h0000;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign mem_rdata1 = pipe1;
   assign mem_rdata3 = pipe3[2];

   fetch_sequencer #(.ADDR_W(16), .INSTR_W(16), .DISP_W(8), .MEM_LAT(1), .RESET_PC(16'h0000)) dut1 (
      .clk(clk), .reset(reset), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
      .instr(instr1), .instr_valid(instr_valid1), .exec_done(exec_done), .stall(stall),
      .br_take(br_take), .br_disp(br_disp), .jmp_take(jmp_take), .jmp_addr(jmp_addr),
      .halt_req(halt_req), .resume(resume), .halted(halted1), .pc(pc1), .retired(retired1),
      .state(state1));

   fetch_sequencer #(.ADDR_W(16), .INSTR_W(16), .DISP_W(8), .MEM_LAT(3), .RESET_PC(16'h0100)) dut3 (
      .clk(clk), .reset(reset), .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
      .instr(instr3), .instr_valid(instr_valid3), .exec_done(1'b1), .stall(1'b0),
      .br_take(1'b0), .br_disp(8'h00), .jmp_take(1'b0), .jmp_addr(16'h0000),
      .halt_req(1'b0), .resume(1'b0), .halted(halted3), .pc(pc3), .retired(retired3),
      .state(state3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample 1 time unit after the edge, and track the latency-3 instance.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         d3_prev   = -1;
         d3_memcnt = 0;
         d3_pc     = 16'h0100;
      end else begin
         if (mem_en3) d3_memcnt++;
         if (instr_valid3) begin
            check("lat3 instr", 32'(instr3), 32'(memf(d3_pc)));
            if (d3_prev >= 0) begin
               check("lat3 period", 32'(cyc - d3_prev), 32'd6);
               check("lat3 mem_en count", 32'(d3_memcnt), 32'd1);
            end
            d3_prev   = cyc;
            d3_memcnt = 0;
            d3_pc     = d3_pc + 16'h0001;
         end
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      logic [15:0] exp_i;
      while (!instr_valid1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " instr_valid"}, 32'(instr_valid1), 32'd1);
      exp_i = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check({tag, " instr"}, 32'(instr1), 32'(exp_i));
      check({tag, " pc during decode"}, 32'(pc1), 32'(model_pc));
   endtask

   task automatic do_instr(input string tag, input logic jt, input logic [15:0] ja,
                           input logic bt, input logic [7:0] bd, input logic hr,
                           input logic [15:0] exp_pc);
      sb.push_back(memf(model_pc));
      wait_valid(tag);
      jmp_take = jt; jmp_addr = ja; br_take = bt; br_disp = bd; halt_req = hr;
      tick();
      check({tag, " exec state"}, 32'(state1), 32'd3);
      check({tag, " valid pulse width"}, 32'(instr_valid1), 32'd0);
      tick();
      model_ret = model_ret + 16'h0001;
      check({tag, " pc"}, 32'(pc1), 32'(exp_pc));
      check({tag, " retired"}, 32'(retired1), 32'(model_ret));
      jmp_take = 1'b0; br_take = 1'b0; br_disp = 8'h00; halt_req = 1'b0; jmp_addr = 16'h0000;
      model_pc = exp_pc;
   endtask

   initial begin
      reset = 1'b1; exec_done = 1'b1; stall = 1'b0; br_take = 1'b0; br_disp = 8'h00;
      jmp_take = 1'b0; jmp_addr = 16'h0000; halt_req = 1'b0; resume = 1'b0;
      model_pc = 16'h0000; model_ret = 16'h0000;
      tick();
      tick();
      check("reset state", 32'(state1), 32'd0);
      check("reset pc", 32'(pc1), 32'h0);
      check("reset instr", 32'(instr1), 32'h0);
      check("reset retired", 32'(retired1), 32'h0);
      check("reset mem_en", 32'(mem_en1), 32'd0);
      check("reset instr_valid", 32'(instr_valid1), 32'd0);
      check("reset halted", 32'(halted1), 32'd0);

      reset = 1'b0;
      #1;
      check("cycle1 mem_en", 32'(mem_en1), 32'd1);
      check("cycle1 mem_addr", 32'(mem_addr1), 32'h0);
      tick();
      check("cycle2 wait", 32'(state1), 32'd1);
      check("cycle2 mem_en low", 32'(mem_en1), 32'd0);
      do_instr("first", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0001);

      do_instr("jmp 0010", 1'b1, 16'h0010, 1'b0, 8'h00, 1'b0, 16'h0010);
      do_instr("br -2", 1'b0, 16'h0000, 1'b1, 8'hFE, 1'b0, 16'h000E);
      do_instr("jmp beats br", 1'b1, 16'h1234, 1'b1, 8'hFE, 1'b0, 16'h1234);
      do_instr("jmp FFFF", 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 16'hFFFF);
      do_instr("wrap seq", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000);
      do_instr("jmp FFFF b", 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 16'hFFFF);
      do_instr("wrap br +2", 1'b0, 16'h0000, 1'b1, 8'h02, 1'b0, 16'h0001);

      sb.push_back(memf(model_pc));
      wait_valid("stall");
      stall = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall hold state", 32'(state1), 32'd3);
         check("stall hold pc", 32'(pc1), 32'(model_pc));
         tick();
      end
      check("stall last state", 32'(state1), 32'd3);
      stall = 1'b0;
      tick();
      model_ret = model_ret + 16'h0001;
      model_pc  = 16'h0002;
      check("stall release pc", 32'(pc1), 32'h0002);
      check("stall release retired", 32'(retired1), 32'(model_ret));

      do_instr("halt", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0003);
      check("halt state", 32'(state1), 32'd4);
      check("halt halted", 32'(halted1), 32'd1);
      check("halt mem_en", 32'(mem_en1), 32'd0);
      jmp_take = 1'b1; jmp_addr = 16'hABCD;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halt pc held", 32'(pc1), 32'h0003);
         check("halt no fetch", 32'(mem_en1), 32'd0);
         check("halt retired held", 32'(retired1), 32'(model_ret));
      end
      jmp_take = 1'b0; jmp_addr = 16'h0000;
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("resume state", 32'(state1), 32'd0);
      check("resume halted", 32'(halted1), 32'd0);
      check("resume mem_en", 32'(mem_en1), 32'd1);

      tick();
      check("pre-reset wait", 32'(state1), 32'd1);
      reset = 1'b1;
      tick();
      check("wait reset state", 32'(state1), 32'd0);
      check("wait reset pc", 32'(pc1), 32'h0);
      check("wait reset instr", 32'(instr1), 32'h0);
      check("wait reset retired", 32'(retired1), 32'h0);
      check("wait reset mem_en", 32'(mem_en1), 32'd0);
      reset = 1'b0;
      model_pc = 16'h0000; model_ret = 16'h0000;
      #1;
      check("refetch mem_en", 32'(mem_en1), 32'd1);
      do_instr("after reset", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0001);

      for (int i = 0; i < 14; i++) tick();
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
